mem_bus_arb: RTL and testbench



---
 rtl/mem_bus_arb.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: shares one external req/ack bus between the I-side fill path
// and the D-side data/I-O path. One transaction at a time, round-robin on
// ties, with a watchdog that turns a hung bus transaction into a faulted ack.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | bus free; arbitrate and latch the winner's request
// BUSY  | bus_req held; wait for bus_ack or watchdog expiry
// DONE  | owner ack pulses this cycle; all requests ignored
module mem_bus_arb #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          ic_req,
    input  logic [AW-1:0] ic_addr,
    output logic          ic_ack,
    output logic [DW-1:0] ic_ack_data,
    output logic          ic_ack_fault,
    input  logic          dc_req,
    input  logic [AW-1:0] dc_addr,
    input  logic          dc_rd,
    input  logic          dc_wr,
    input  logic [DW-1:0] dc_wr_data,
    output logic          dc_ack,
    output logic [DW-1:0] dc_ack_data,
    output logic          dc_ack_fault,
    output logic          bus_req,
    output logic [AW-1:0] bus_addr,
    output logic          bus_rd,
    output logic          bus_wr,
    output logic [DW-1:0] bus_wr_data,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_ack_data,
    input  logic          bus_ack_fault
);

    // A zero limit disables the watchdog; keep the counter at least one bit.
    localparam int WD_W = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_d;   // last grant: 0 = I side, 1 = D side
    logic            r_owner_d;  // current owner: 0 = I side, 1 = D side
    logic [WD_W-1:0] r_wd;

    logic            w_grant;
    logic            w_grant_d;
    logic            w_bus_done;
    logic            w_timeout;
    logic            w_wd_hit;

    logic            r_bus_req;
    logic [AW-1:0]   r_bus_addr;
    logic            r_bus_rd;
    logic            r_bus_wr;
    logic [DW-1:0]   r_bus_wr_data;
    logic            r_ic_ack;
    logic [DW-1:0]   r_ic_ack_data;
    logic            r_ic_ack_fault;
    logic            r_dc_ack;
    logic [DW-1:0]   r_dc_ack_data;
    logic            r_dc_ack_fault;

    assign w_wd_hit = (TO_CYC != 0) && (r_wd == WD_W'(TO_CYC));

    // Next-state and arbitration decode; bus_ack beats the watchdog on a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        w_bus_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    w_grant     = 1'b1;
                    w_grant_d   = (ic_req && dc_req) ? ~r_last_d : dc_req;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus_ack) begin
                    w_bus_done  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_wd_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Bus request registers, ownership, watchdog and single-cycle ack pulses.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_last_d       <= 1'b0;
            r_owner_d      <= 1'b0;
            r_wd           <= '0;
            r_bus_req      <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_rd       <= 1'b0;
            r_bus_wr       <= 1'b0;
            r_bus_wr_data  <= '0;
            r_ic_ack       <= 1'b0;
            r_ic_ack_data  <= '0;
            r_ic_ack_fault <= 1'b0;
            r_dc_ack       <= 1'b0;
            r_dc_ack_data  <= '0;
            r_dc_ack_fault <= 1'b0;
        end else begin
            r_ic_ack       <= 1'b0;
            r_ic_ack_data  <= '0;
            r_ic_ack_fault <= 1'b0;
            r_dc_ack       <= 1'b0;
            r_dc_ack_data  <= '0;
            r_dc_ack_fault <= 1'b0;
            if (w_grant) begin
                r_bus_req     <= 1'b1;
                r_bus_addr    <= w_grant_d ? dc_addr : ic_addr;
                r_bus_rd      <= w_grant_d ? dc_rd : 1'b1;
                r_bus_wr      <= w_grant_d ? dc_wr : 1'b0;
                r_bus_wr_data <= w_grant_d ? dc_wr_data : '0;
                r_owner_d     <= w_grant_d;
                r_last_d      <= w_grant_d;
                r_wd          <= '0;
            end else if (w_bus_done || w_timeout) begin
                r_bus_req <= 1'b0;
                r_bus_rd  <= 1'b0;
                r_bus_wr  <= 1'b0;
                if (r_owner_d) begin
                    r_dc_ack       <= 1'b1;
                    r_dc_ack_data  <= w_bus_done ? bus_ack_data : '0;
                    r_dc_ack_fault <= w_bus_done ? bus_ack_fault : 1'b1;
                end else begin
                    r_ic_ack       <= 1'b1;
                    r_ic_ack_data  <= w_bus_done ? bus_ack_data : '0;
                    r_ic_ack_fault <= w_bus_done ? bus_ack_fault : 1'b1;
                end
            end else if (r_state == S_BUSY && r_wd != '1) begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    assign bus_req      = r_bus_req;
    assign bus_addr     = r_bus_addr;
    assign bus_rd       = r_bus_rd;
    assign bus_wr       = r_bus_wr;
    assign bus_wr_data  = r_bus_wr_data;
    assign ic_ack       = r_ic_ack;
    assign ic_ack_data  = r_ic_ack_data;
    assign ic_ack_fault = r_ic_ack_fault;
    assign dc_ack       = r_dc_ack;
    assign dc_ack_data  = r_dc_ack_data;
    assign dc_ack_fault = r_dc_ack_fault;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb, built with a 4-cycle watchdog.
module tb_mem_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_ack;
    logic [DW-1:0] ic_ack_data;
    logic          ic_ack_fault;
    logic          dc_req;
    logic [AW-1:0] dc_addr;
    logic          dc_rd;
    logic          dc_wr;
    logic [DW-1:0] dc_wr_data;
    logic          dc_ack;
    logic [DW-1:0] dc_ack_data;
    logic          dc_ack_fault;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic          bus_rd;
    logic          bus_wr;
    logic [DW-1:0] bus_wr_data;
    logic          bus_ack;
    logic [DW-1:0] bus_ack_data;
    logic          bus_ack_fault;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arb #(.AW(AW), .DW(DW), .TO_CYC(4)) u_dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_ack        (ic_ack),
        .ic_ack_data   (ic_ack_data),
        .ic_ack_fault  (ic_ack_fault),
        .dc_req        (dc_req),
        .dc_addr       (dc_addr),
        .dc_rd         (dc_rd),
        .dc_wr         (dc_wr),
        .dc_wr_data    (dc_wr_data),
        .dc_ack        (dc_ack),
        .dc_ack_data   (dc_ack_data),
        .dc_ack_fault  (dc_ack_fault),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_rd        (bus_rd),
        .bus_wr        (bus_wr),
        .bus_wr_data   (bus_wr_data),
        .bus_ack       (bus_ack),
        .bus_ack_data  (bus_ack_data),
        .bus_ack_fault (bus_ack_fault)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled and
    // inputs written here are sampled at the following edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bus"}, {61'd0, bus_req, bus_rd, bus_wr}, 64'd0);
        check({tag, " addr"}, {32'd0, bus_addr}, 64'd0);
        check({tag, " wdata"}, {32'd0, bus_wr_data}, 64'd0);
        check({tag, " acks"}, {60'd0, ic_ack, ic_ack_fault, dc_ack, dc_ack_fault}, 64'd0);
        check({tag, " ackdata"}, {ic_ack_data, dc_ack_data}, 64'd0);
    endtask

    // Tie with both sides requesting: D must win, then I.
    task automatic run_tie(input string tag);
        ic_req  = 1'b1; ic_addr = 32'h0000_1000;
        dc_req  = 1'b1; dc_addr = 32'h0000_2000; dc_rd = 1'b1; dc_wr = 1'b0;
        tick();
        check({tag, " first D"}, {32'd0, bus_addr}, 64'h2000);
        bus_ack = 1'b1; bus_ack_data = 32'h0000_00D1;
        tick();
        bus_ack = 1'b0;
        check({tag, " D ack"}, {62'd0, dc_ack, ic_ack}, 64'b10);
        check({tag, " D data"}, {32'd0, dc_ack_data}, 64'hD1);
        dc_req = 1'b0;
        tick();
        check({tag, " D pulse"}, {62'd0, dc_ack, ic_ack}, 64'b00);
        tick();
        check({tag, " then I"}, {31'd0, bus_req, bus_addr}, {31'd0, 1'b1, 32'h1000});
        bus_ack = 1'b1; bus_ack_data = 32'h0000_00A1;
        tick();
        bus_ack = 1'b0;
        check({tag, " I ack"}, {62'd0, dc_ack, ic_ack}, 64'b01);
        ic_req = 1'b0;
        tick();
        check({tag, " I pulse"}, {62'd0, dc_ack, ic_ack}, 64'b00);
    endtask

    initial begin
        reset_in = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_addr = '0; dc_rd = 1'b0; dc_wr = 1'b0; dc_wr_data = '0;
        bus_ack = 1'b0; bus_ack_data = '0; bus_ack_fault = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset_in = 1'b0;
        tick();

        // Single I read, bus_ack in the third BUSY cycle.
        ic_req = 1'b1; ic_addr = 32'h0000_1000;
        tick();
        check("i rd strobes", {61'd0, bus_req, bus_rd, bus_wr}, 64'b110);
        check("i rd addr", {32'd0, bus_addr}, 64'h1000);
        tick();
        tick();
        check("i rd held", {63'd0, bus_req}, 64'd1);
        bus_ack = 1'b1; bus_ack_data = 32'hDEAD_BEEF;
        tick();
        bus_ack = 1'b0; ic_req = 1'b0;
        check("i rd ack", {60'd0, ic_ack, ic_ack_fault, dc_ack, bus_req}, 64'b1000);
        check("i rd data", {32'd0, ic_ack_data}, 64'hDEAD_BEEF);
        tick();
        check("i rd pulse", {31'd0, ic_ack, ic_ack_data}, 64'd0);

        // Ties after reset alternate D then I, twice.
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        run_tie("tie1");
        run_tie("tie2");

        // D write.
        dc_req = 1'b1; dc_rd = 1'b0; dc_wr = 1'b1;
        dc_addr = 32'h8000_0010; dc_wr_data = 32'h1234_5678;
        tick();
        check("d wr strobes", {61'd0, bus_req, bus_rd, bus_wr}, 64'b101);
        check("d wr addr", {bus_addr, bus_wr_data}, {32'h8000_0010, 32'h1234_5678});
        bus_ack = 1'b1; bus_ack_data = '0;
        tick();
        bus_ack = 1'b0; dc_req = 1'b0; dc_wr = 1'b0;
        check("d wr ack", {61'd0, dc_ack, dc_ack_fault, ic_ack}, 64'b100);
        check("d wr data", {32'd0, dc_ack_data}, 64'd0);
        check("d wr drop", {61'd0, bus_req, bus_rd, bus_wr}, 64'd0);
        tick();

        // Watchdog timeout: bus_req high 5 cycles, then faulted ack.
        dc_req = 1'b1; dc_rd = 1'b1; dc_addr = 32'h0000_3000;
        bus_ack_data = 32'hFFFF_FFFF;
        tick();
        check("to req1", {63'd0, bus_req}, 64'd1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check($sformatf("to req%0d", i), {62'd0, bus_req, dc_ack}, 64'b10);
        end
        tick();
        dc_req = 1'b0;
        check("to ack", {61'd0, dc_ack, dc_ack_fault, bus_req}, 64'b110);
        check("to data", {32'd0, dc_ack_data}, 64'd0);
        tick();
        check("to pulse", {63'd0, dc_ack}, 64'd0);
        tick();
        bus_ack = 1'b1; bus_ack_fault = 1'b1;
        tick();
        bus_ack = 1'b0; bus_ack_fault = 1'b0;
        check("late ack", {61'd0, dc_ack, ic_ack, bus_req}, 64'd0);
        tick();
        check("late ack2", {62'd0, dc_ack, ic_ack}, 64'd0);

        // Bus fault on an I read leaves D untouched.
        ic_req = 1'b1; ic_addr = 32'h0000_4000;
        tick();
        bus_ack = 1'b1; bus_ack_fault = 1'b1; bus_ack_data = 32'h0000_A5A5;
        tick();
        bus_ack = 1'b0; bus_ack_fault = 1'b0; ic_req = 1'b0;
        check("fault i", {62'd0, ic_ack, ic_ack_fault}, 64'b11);
        check("fault i data", {32'd0, ic_ack_data}, 64'hA5A5);
        check("fault d quiet", {30'd0, dc_ack, dc_ack_fault, dc_ack_data}, 64'd0);
        tick();

        // bus_ack coincident with watchdog expiry: normal completion wins.
        dc_req = 1'b1; dc_rd = 1'b1; dc_addr = 32'h0000_5000;
        tick();
        for (int i = 0; i < 4; i++) tick();
        bus_ack = 1'b1; bus_ack_fault = 1'b0; bus_ack_data = 32'h0000_55AA;
        tick();
        bus_ack = 1'b0; dc_req = 1'b0;
        check("coinc ack", {62'd0, dc_ack, dc_ack_fault}, 64'b10);
        check("coinc data", {32'd0, dc_ack_data}, 64'h55AA);
        tick();

        // Reset while D is BUSY: no ack, outputs cleared, tie then goes to D.
        dc_req = 1'b1; dc_addr = 32'h0000_6000;
        tick();
        tick();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check_all_zero("rst busy");
        ic_req = 1'b1; ic_addr = 32'h0000_7000;
        tick();
        check("rst tie D", {31'd0, bus_req, bus_addr}, {31'd0, 1'b1, 32'h6000});
        check("rst no ack", {62'd0, dc_ack, ic_ack}, 64'd0);
        bus_ack = 1'b1; bus_ack_data = 32'h0000_0066;
        tick();
        bus_ack = 1'b0; dc_req = 1'b0; ic_req = 1'b0;
        check("rst D ack", {62'd0, dc_ack, ic_ack}, 64'b10);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
